// File: rtl/wb_chk_pkg.sv
// Shared types and default sizing for the writeback result checker.
package wb_chk_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_LANE_W = 16;
    localparam int DEF_DEPTH  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

endpackage

// File: rtl/wb_result_checker_lane_compare.sv
// Combinational per-lane inequality between two result words.
module lane_compare
    import wb_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANE_W = DEF_LANE_W
) (
    input  logic [DATA_W-1:0]        a,
    input  logic [DATA_W-1:0]        b,
    output logic [DATA_W/LANE_W-1:0] mismatch
);

    localparam int NL = DATA_W / LANE_W;

    // One mismatch bit per lane, lane 0 in the least significant bits
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NL; i++) begin
            mismatch[i] = (a[i*LANE_W +: LANE_W] != b[i*LANE_W +: LANE_W]);
        end
    end

endmodule

// File: rtl/wb_result_checker.sv
// Compares a stream of writeback results against a preloaded expected table.
// Optional macro WB_CHK_STOP_ON_ERR_EN: end the run on the first mismatch.
module wb_result_checker
    import wb_chk_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  LANE_W = DEF_LANE_W,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NL     = DATA_W / LANE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_wr_en,
    input  logic [AW-1:0]     exp_wr_addr,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic              start,
    input  logic [AW:0]       num_results,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW:0]       err_cnt,
    output logic [AW-1:0]     first_err_idx,
    output logic [NL-1:0]     lane_mismatch
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ERR_MAX = {(AW+1){1'b1}};
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1'b1);

    chk_state_e        state_r, state_s;
    logic [DATA_W-1:0] table_r [DEPTH];
    logic [AW-1:0]     idx_r, idx_s;
    logic [AW:0]       num_r, num_s, num_clamp_s;
    logic [AW:0]       err_cnt_r, err_cnt_s;
    logic [AW-1:0]     first_err_idx_r, first_err_idx_s;
    logic [NL-1:0]     lane_mismatch_r, lane_mismatch_s;
    logic [NL-1:0]     mm_s;
    logic              busy_r, done_r, pass_r;
    logic              accept_s, start_ok_s, last_s, hit_s, finish_s;

    lane_compare #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_lane_compare (
        .a        (res_data),
        .b        (table_r[idx_r]),
        .mismatch (mm_s)
    );

    assign accept_s   = (state_r == ST_RUN) && res_valid;
    assign start_ok_s = start && (state_r != ST_RUN);
    assign last_s     = ({1'b0, idx_r} == (num_r - CNT_ONE));
    assign hit_s      = |mm_s;
    assign num_clamp_s = (num_results > DEPTH_C) ? DEPTH_C : num_results;

`ifdef WB_CHK_STOP_ON_ERR_EN
    assign finish_s = accept_s && (last_s || hit_s);
`else
    assign finish_s = accept_s && last_s;
`endif

    // Next-state logic for the run controller
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = (num_clamp_s != '0) ? ST_RUN : ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (finish_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the run index, limit and compare results
    always_comb begin
        idx_s           = idx_r;
        num_s           = num_r;
        err_cnt_s       = err_cnt_r;
        first_err_idx_s = first_err_idx_r;
        lane_mismatch_s = lane_mismatch_r;
        if (start_ok_s) begin
            idx_s           = '0;
            num_s           = num_clamp_s;
            err_cnt_s       = '0;
            first_err_idx_s = '0;
            lane_mismatch_s = '0;
        end else if (accept_s) begin
            lane_mismatch_s = mm_s;
            // err_cnt never wraps to zero, so zero means no mismatch yet this run
            if (hit_s && (err_cnt_r == '0)) begin
                first_err_idx_s = idx_r;
            end else begin
                first_err_idx_s = first_err_idx_r;
            end
            if (hit_s && (err_cnt_r != ERR_MAX)) begin
                err_cnt_s = err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_s = err_cnt_r;
            end
            if (finish_s) begin
                idx_s = idx_r;
            end else begin
                idx_s = idx_r + AW'(1'b1);
            end
        end else begin
            idx_s = idx_r;
        end
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and status output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_r           <= '0;
            num_r           <= '0;
            err_cnt_r       <= '0;
            first_err_idx_r <= '0;
            lane_mismatch_r <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
        end else begin
            idx_r           <= idx_s;
            num_r           <= num_s;
            err_cnt_r       <= err_cnt_s;
            first_err_idx_r <= first_err_idx_s;
            lane_mismatch_r <= lane_mismatch_s;
            busy_r          <= (state_s == ST_RUN);
            done_r          <= (state_s == ST_DONE);
            pass_r          <= (state_s == ST_DONE) && (err_cnt_s == '0);
        end
    end

    // Expected table is loaded only while no run is active and survives reset
    always_ff @(posedge clk) begin
        if (exp_wr_en && (state_r != ST_RUN)) begin
            table_r[exp_wr_addr] <= exp_wr_data;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_cnt       = err_cnt_r;
    assign first_err_idx = first_err_idx_r;
    assign lane_mismatch = lane_mismatch_r;

endmodule

// File: tb/tb_wb_result_checker.sv
// Directed, scoreboard-based bench for wb_result_checker (default parameters).
module tb_wb_result_checker;

    localparam int DATA_W = 128;
    localparam int AW     = 6;
    localparam int NL     = 8;
`ifdef WB_CHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              exp_wr_en;
    logic [AW-1:0]     exp_wr_addr;
    logic [DATA_W-1:0] exp_wr_data;
    logic              start;
    logic [AW:0]       num_results;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              busy, done, pass;
    logic [AW:0]       err_cnt;
    logic [AW-1:0]     first_err_idx;
    logic [NL-1:0]     lane_mismatch;

    wb_result_checker dut (
        .clk           (clk),
        .reset         (reset),
        .exp_wr_en     (exp_wr_en),
        .exp_wr_addr   (exp_wr_addr),
        .exp_wr_data   (exp_wr_data),
        .start         (start),
        .num_results   (num_results),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .lane_mismatch (lane_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0] lm;
        int            err;
        int            first;
    } exp_t;

    exp_t              sb[$];
    int                pass_cnt = 0;
    int                fail_cnt = 0;
    int                total_cnt = 0;
    logic [DATA_W-1:0] m_table [64];
    int                m_idx, m_num, m_err, m_first;
    logic [NL-1:0]     m_lm;
    bit                m_run, m_done;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [NL-1:0] lane_diff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [NL-1:0] d;
        d = '0;
        for (int i = 0; i < NL; i++) begin
            d[i] = (a[i*16 +: 16] !== b[i*16 +: 16]);
        end
        return d;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_busy"}, busy, m_run);
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_pass"}, pass, m_done && (m_err == 0));
        chk({tag, "_err"}, err_cnt, m_err);
        chk({tag, "_first"}, first_err_idx, m_first);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        m_run = 0; m_done = 0; m_err = 0; m_first = 0; m_idx = 0; m_lm = '0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err", err_cnt, 0);
        chk("rst_first", first_err_idx, 0);
        chk("rst_lanes", lane_mismatch, 0);
        reset = 1'b1;
    endtask

    task automatic write_exp(input int addr, input logic [DATA_W-1:0] data);
        exp_wr_en = 1'b1; exp_wr_addr = AW'(addr); exp_wr_data = data;
        step();
        exp_wr_en = 1'b0;
        if (!m_run) m_table[addr] = data;
    endtask

    task automatic do_start(input int n);
        start = 1'b1; num_results = (AW+1)'(n);
        step();
        start = 1'b0;
        if (!m_run) begin
            m_idx = 0; m_err = 0; m_first = 0; m_lm = '0;
            m_num = (n > 64) ? 64 : n;
            m_run = (m_num > 0);
            m_done = !m_run;
        end
        check_status("start");
    endtask

    task automatic send(input logic [DATA_W-1:0] data);
        exp_t e;
        logic [NL-1:0] mm;
        res_valid = 1'b1; res_data = data;
        if (m_run) begin
            mm = lane_diff(data, m_table[m_idx]);
            m_lm = mm;
            if (mm != '0) begin
                if (m_err == 0) m_first = m_idx;
                if (m_err < 127) m_err++;
            end
            if ((m_idx == m_num - 1) || (STOP && (mm != '0))) begin
                m_run = 0; m_done = 1;
            end else begin
                m_idx++;
            end
        end
        sb.push_back('{m_lm, m_err, m_first});
        step();
        res_valid = 1'b0;
        e = sb.pop_front();
        chk("res_lanes", lane_mismatch, e.lm);
        chk("res_err", err_cnt, e.err);
        chk("res_first", first_err_idx, e.first);
    endtask

    initial begin
        logic [DATA_W-1:0] bad;
        reset = 1'b0; exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
        start = 1'b0; num_results = '0; res_valid = 1'b0; res_data = '0;
        step();
        do_reset();
        for (int i = 0; i < 4; i++) write_exp(i, DATA_W'(i + 1));

        // clean run of four
        do_start(4);
        chk("run_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) send(DATA_W'(i + 1));
        chk("clean_done", done, 1'b1);
        chk("clean_pass", pass, 1'b1);
        chk("clean_err", err_cnt, 0);
        chk("clean_busy", busy, 1'b0);
        send(DATA_W'(99));
        chk("done_ignore_err", err_cnt, 0);

        // lane 7 mismatch at index 2
        do_start(4);
        send(DATA_W'(1));
        send(DATA_W'(2));
        bad = {16'h0003, 96'h0, 16'h0003};
        send(bad);
        chk("lane7_mask", lane_mismatch, 8'h80);
        chk("lane7_err", err_cnt, 1);
        chk("lane7_first", first_err_idx, 2);
        chk("lane7_pass", pass, 1'b0);
        send(DATA_W'(4));
        check_status("lane7_end");

        // empty run
        do_start(0);
        chk("empty_done", done, 1'b1);
        chk("empty_pass", pass, 1'b1);
        chk("empty_busy", busy, 1'b0);

        // reset mid-run, then a clean restart
        do_start(4);
        send(DATA_W'(1));
        send(DATA_W'(2));
        do_reset();
        step();
        chk("abort_done", done, 1'b0);
        chk("abort_busy", busy, 1'b0);
        do_start(4);
        for (int i = 0; i < 4; i++) send(DATA_W'(i + 1));
        chk("restart_pass", pass, 1'b1);

        // mismatch at index 1, later results follow
        do_start(4);
        send(DATA_W'(1));
        send(DATA_W'(32'h77));
        check_status("idx1_hit");
        chk("idx1_err", err_cnt, 1);
        chk("idx1_first", first_err_idx, 1);
        send(DATA_W'(3));
        send(DATA_W'(4));
        check_status("idx1_end");
        chk("idx1_err_end", err_cnt, 1);

        // table write during a run is dropped
        do_start(2);
        write_exp(0, DATA_W'(32'hdead));
        send(DATA_W'(1));
        send(DATA_W'(2));
        do_start(1);
        send(DATA_W'(1));
        chk("wr_run_pass", pass, 1'b1);
        chk("wr_run_lanes", lane_mismatch, 0);

        // oversize count clamps to the full table; start during run ignored
        for (int i = 4; i < 64; i++) write_exp(i, DATA_W'(i + 1));
        do_start(100);
        for (int i = 0; i < 30; i++) send(DATA_W'(i + 1));
        do_start(0);
        chk("run_start_ignored", busy, 1'b1);
        for (int i = 30; i < 64; i++) send(DATA_W'(i + 1));
        chk("clamp_done", done, 1'b1);
        chk("clamp_pass", pass, 1'b1);
        chk("clamp_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_result_checker.md
WB_RESULT_CHECKER -- requirements
Module: wb_result_checker

Interface
REQ-001 Parameter DATA_W, default 128: width of one writeback result word.
REQ-002 Parameter LANE_W, default 16: lane width for per-lane compare; DATA_W SHALL be a multiple of LANE_W.
REQ-003 Parameter DEPTH, default 64: expected-result table entries; AW = $clog2(DEPTH).
REQ-004 clk  in  1: single clock, rising edge.
REQ-005 reset  in  1: synchronous, active-low reset (asserted at 0).
REQ-006 exp_wr_en / exp_wr_addr / exp_wr_data  in  1 / AW / DATA_W: expected-table write port.
REQ-007 start  in  1: one-cycle pulse that begins a check run.
REQ-008 num_results  in  AW+1: number of results to check; sampled on start.
REQ-009 res_valid / res_data  in  1 / DATA_W: writeback result strobe and value (wb_alu_result).
REQ-010 busy  out  1: run in progress.
REQ-011 done  out  1: run complete; held until next start or reset.
REQ-012 pass  out  1: valid while done; 1 iff err_cnt==0.
REQ-013 err_cnt  out  AW+1: mismatch count, saturating.
REQ-014 first_err_idx  out  AW: index of first mismatch; 0 if none.
REQ-015 lane_mismatch  out  DATA_W/LANE_W: per-lane mismatch of most recent compare.

Function
REQ-016 FSM states IDLE, RUN, DONE; reset enters IDLE.
REQ-017 IDLE->RUN on start with num_results>0; IDLE->DONE on start with num_results==0, pass=1.
REQ-018 In RUN, each res_valid compares res_data to table[idx], idx starting at 0 and incrementing by 1 per accepted result.
REQ-019 Compare results (lane_mismatch, err_cnt, first_err_idx) SHALL be registered, visible the cycle after res_valid.
REQ-020 RUN->DONE on the edge registering the compare with idx==num_results-1; done rises that same edge.
REQ-021 res_valid SHALL be ignored in IDLE and DONE; counters unchanged.
REQ-022 err_cnt SHALL saturate at 2^(AW+1)-1; first_err_idx written only on first mismatch of a run.
REQ-023 start in DONE SHALL clear idx, err_cnt, first_err_idx, lane_mismatch and re-enter RUN or DONE per REQ-017; start in RUN ignored.
REQ-024 exp_wr_en honoured only in IDLE or DONE; ignored in RUN.
REQ-025 idx SHALL never exceed DEPTH-1; num_results>DEPTH is clamped to DEPTH.

Reset
REQ-026 With reset==0 at an edge: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, lane_mismatch=0, idx=0; table contents not cleared.
REQ-027 Reset mid-run SHALL abort the run with no done pulse.

Configuration
REQ-028 Macro WB_CHK_STOP_ON_ERR_EN defined: first mismatch moves RUN->DONE on the registering edge, pass=0, err_cnt=1.
REQ-029 Macro undefined: run continues through all num_results results, counting every mismatch.

Structure
REQ-030 Package wb_chk_pkg SHALL hold the state enum and default DATA_W/LANE_W/DEPTH constants.
REQ-031 Sub-module lane_compare (combinational, parametrised by DATA_W/LANE_W) SHALL produce the per-lane mismatch vector.

Verification
REQ-032 Load table[0..3]=1,2,3,4; start, num_results=4; results 1,2,3,4 -> done=1, pass=1, err_cnt=0 one cycle after 4th res_valid.
REQ-033 Same table; result[2]=0x0003_0000...0003 differing in lane 7 only -> lane_mismatch=8'h80 after that compare, err_cnt=1, first_err_idx=2, pass=0.
REQ-034 start with num_results=0 -> done=1, pass=1 next cycle, busy never asserted.
REQ-035 reset=0 after 2 of 4 results -> all outputs 0, state IDLE; new start runs cleanly from idx 0.
REQ-036 WB_CHK_STOP_ON_ERR_EN defined, mismatch at idx 1 of 4 -> done next cycle, err_cnt=1, later res_valid ignored.
REQ-037 exp_wr_en during RUN to addr 0 -> table unchanged; subsequent run checks original value.
